// File: rtl/sbh_rmw.sv
// Store byte/halfword unit: read-modify-write of one lane into a word-wide memory.
// Latency: word store 2 cycles, byte/halfword 3 cycles, plus one per memory wait cycle.
// Backpressure: mem_rd/mem_wr held until mem_rvalid/mem_wack; busy stalls the CPU meanwhile.
module sbh_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        sbh_c,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_wack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_half;
    logic [1:0]        r_lane;
    logic [15:0]       r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_done;
    logic [31:0]       w_merged;

    // Big-endian lanes: offset 0 is the most significant byte, matching the load side.
    always_comb begin
        w_merged = mem_rdata;
        if (r_half) begin
            if (r_lane[1]) w_merged[15:0]  = r_data;
            else           w_merged[31:16] = r_data;
        end else begin
            case (r_lane)
                2'd0:    w_merged[31:24] = r_data[7:0];
                2'd1:    w_merged[23:16] = r_data[7:0];
                2'd2:    w_merged[15:8]  = r_data[7:0];
                default: w_merged[7:0]   = r_data[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_half  <= 1'b0;
            r_lane  <= 2'd0;
            r_data  <= 16'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_half <= (sbh_c == 2'd2);
                        r_lane <= addr[1:0];
                        r_data <= data_in[15:0];
                        r_addr <= {addr[ADDR_W-1:2], 2'b00};
                        if (sbh_c == 2'd0 || sbh_c == 2'd3) begin
                            r_wdata <= data_in;
                            r_state <= WR;
                        end else begin
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_rvalid) begin
                        r_wdata <= w_merged;
                        r_state <= WR;
                    end
                end
                WR: begin
                    if (mem_wack) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign mem_rd    = (r_state == RD);
    assign mem_wr    = (r_state == WR);
    assign done      = r_done;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_sbh_rmw.sv
// Directed bench for sbh_rmw: lane merges, word path, wait states, ignored inputs, reset.
module tb_sbh_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  sbh_c;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_wack;

    int total = 0;
    int bad   = 0;

    // observations recorded by run_store
    int          o_rd_first, o_rd_cnt, o_wr_first, o_wr_cnt, o_done_cyc, o_done_cnt;
    logic [31:0] o_wdata, o_addr;
    logic        o_stable, o_busy_done, o_timeout;

    sbh_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sbh_c      (sbh_c),
        .addr       (addr),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .mem_wack   (mem_wack)
    );

    always #5 clk = ~clk;

    // Issues one store and plays the memory; inputs are scrambled right after acceptance.
    task automatic run_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] rdata, input int rwait, input int wwait);
        o_rd_first = 0; o_rd_cnt = 0; o_wr_first = 0; o_wr_cnt = 0;
        o_done_cyc = 0; o_done_cnt = 0; o_wdata = '0; o_addr = '0;
        o_stable = 1'b1; o_busy_done = 1'b1; o_timeout = 1'b1;
        @(negedge clk);
        start = 1'b1; sbh_c = sz; addr = a; data_in = d; mem_rdata = rdata;
        @(posedge clk);
        #1;
        start = 1'b0; sbh_c = ~sz; addr = ~a; data_in = ~d;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) o_addr = mem_addr;
            if (mem_rd) begin
                if (o_rd_first == 0) o_rd_first = c;
                o_rd_cnt++;
            end
            if (mem_wr) begin
                if (o_wr_first == 0) begin
                    o_wr_first = c;
                    o_wdata = mem_wdata;
                end else if (mem_wdata !== o_wdata) begin
                    o_stable = 1'b0;
                end
                o_wr_cnt++;
            end
            if (done) begin
                if (o_done_cyc == 0) begin
                    o_done_cyc = c;
                    o_busy_done = busy;
                end
                o_done_cnt++;
            end
            mem_rvalid = mem_rd && (o_rd_cnt > rwait);
            mem_wack   = mem_wr && (o_wr_cnt > wwait);
            if (o_done_cyc != 0 && c > o_done_cyc) begin
                o_timeout = 1'b0;
                break;
            end
        end
        mem_rvalid = 1'b0;
        mem_wack   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sbh_c = 2'd0; addr = '0; data_in = '0;
        mem_rdata = '0; mem_rvalid = 1'b0; mem_wack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== 68'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h, need all 0",
                     busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, mem_rd, mem_wr} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got busy/rd/wr=%b%b%b, need 000", busy, mem_rd, mem_wr);
        end
    endtask

    task automatic test_byte_store;
        run_store(2'd1, 32'h0000_1001, 32'h0000_00AB, 32'h1122_3344, 0, 0);
        total++;
        if (o_timeout !== 1'b0) begin bad++; $display("FAIL byte_timeout: no done within budget"); end
        total++;
        if (o_addr !== 32'h0000_1000) begin bad++; $display("FAIL byte_addr: got %h need 00001000", o_addr); end
        total++;
        if (o_rd_first != 1 || o_rd_cnt != 1) begin
            bad++; $display("FAIL byte_rd: first=%0d cnt=%0d need 1/1", o_rd_first, o_rd_cnt);
        end
        total++;
        if (o_wr_first != 2 || o_wr_cnt != 1) begin
            bad++; $display("FAIL byte_wr: first=%0d cnt=%0d need 2/1", o_wr_first, o_wr_cnt);
        end
        total++;
        if (o_wdata !== 32'h11AB_3344) begin bad++; $display("FAIL byte_wdata: got %h need 11ab3344", o_wdata); end
        total++;
        if (o_done_cyc != 3 || o_done_cnt != 1 || o_busy_done !== 1'b0) begin
            bad++; $display("FAIL byte_done: cyc=%0d cnt=%0d busy=%b need 3/1/0", o_done_cyc, o_done_cnt, o_busy_done);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hAB22_3344; exp_w[1] = 32'h11AB_3344;
        exp_w[2] = 32'h1122_AB44; exp_w[3] = 32'h1122_33AB;
        for (int k = 0; k < 4; k++) begin
            run_store(2'd1, 32'h0000_7000 + k, 32'hFFFF_FFAB, 32'h1122_3344, 0, 0);
            total++;
            if (o_wdata !== exp_w[k] || o_timeout !== 1'b0) begin
                bad++; $display("FAIL byte_lane%0d: got %h timeout=%b need %h", k, o_wdata, o_timeout, exp_w[k]);
            end
        end
    endtask

    task automatic test_halfword;
        logic [31:0] a_v [3];
        logic [31:0] exp_w [3];
        a_v[0] = 32'h0000_2002; exp_w[0] = 32'h1122_BEEF;
        a_v[1] = 32'h0000_2000; exp_w[1] = 32'hBEEF_3344;
        a_v[2] = 32'h0000_2003; exp_w[2] = 32'h1122_BEEF;
        for (int k = 0; k < 3; k++) begin
            run_store(2'd2, a_v[k], 32'hFFFF_BEEF, 32'h1122_3344, 0, 0);
            total++;
            if (o_wdata !== exp_w[k] || o_addr !== 32'h0000_2000 || o_done_cyc != 3) begin
                bad++;
                $display("FAIL half_%h: wdata=%h addr=%h done_cyc=%0d need %h/00002000/3",
                         a_v[k], o_wdata, o_addr, o_done_cyc, exp_w[k]);
            end
        end
    endtask

    task automatic test_word;
        run_store(2'd3, 32'h0000_3004, 32'hDEAD_BEEF, 32'h1122_3344, 0, 0);
        total++;
        if (o_rd_cnt != 0) begin bad++; $display("FAIL word_no_rd: got rd cycles=%0d need 0", o_rd_cnt); end
        total++;
        if (o_wr_first != 1 || o_wdata !== 32'hDEAD_BEEF || o_addr !== 32'h0000_3004) begin
            bad++; $display("FAIL word_wr: first=%0d wdata=%h addr=%h need 1/deadbeef/00003004", o_wr_first, o_wdata, o_addr);
        end
        total++;
        if (o_done_cyc != 2 || o_done_cnt != 1) begin
            bad++; $display("FAIL word_done: cyc=%0d cnt=%0d need 2/1", o_done_cyc, o_done_cnt);
        end
        run_store(2'd0, 32'h0000_3008, 32'h0BAD_F00D, 32'h1122_3344, 0, 0);
        total++;
        if (o_rd_cnt != 0 || o_wdata !== 32'h0BAD_F00D || o_done_cyc != 2) begin
            bad++; $display("FAIL word_sz0: rd=%0d wdata=%h done_cyc=%0d need 0/0badf00d/2", o_rd_cnt, o_wdata, o_done_cyc);
        end
    endtask

    task automatic test_wait_states;
        run_store(2'd1, 32'h0000_1002, 32'h0000_00CD, 32'h1122_3344, 3, 2);
        total++;
        if (o_rd_cnt != 4 || o_wr_cnt != 3) begin
            bad++; $display("FAIL wait_hold: rd=%0d wr=%0d need 4/3", o_rd_cnt, o_wr_cnt);
        end
        total++;
        if (o_stable !== 1'b1 || o_wdata !== 32'h1122_CD44) begin
            bad++; $display("FAIL wait_wdata: stable=%b wdata=%h need 1/1122cd44", o_stable, o_wdata);
        end
        total++;
        if (o_done_cyc != 8 || o_done_cnt != 1) begin
            bad++; $display("FAIL wait_done: cyc=%0d cnt=%0d need 8/1", o_done_cyc, o_done_cnt);
        end
    endtask

    task automatic test_ignored_inputs;
        @(negedge clk);
        start = 1'b1; sbh_c = 2'd1; addr = 32'h0000_1003; data_in = 32'h0000_0055;
        mem_rdata = 32'hAABB_CCDD;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; sbh_c = 2'd3; addr = 32'h0000_4000; data_in = 32'h1234_5678; mem_wack = 1'b1;
        @(negedge clk);
        total++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL ign_rd: rd=%b wr=%b need 1/0", mem_rd, mem_wr);
        end
        start = 1'b0; mem_wack = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        total++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'hAABB_CC55 || mem_addr !== 32'h0000_1000) begin
            bad++; $display("FAIL ign_wr: wr=%b wdata=%h addr=%h need 1/aabbcc55/00001000", mem_wr, mem_wdata, mem_addr);
        end
        @(negedge clk);
        total++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'hAABB_CC55 || done !== 1'b0) begin
            bad++; $display("FAIL ign_rvalid: wr=%b wdata=%h done=%b need 1/aabbcc55/0", mem_wr, mem_wdata, done);
        end
        mem_rvalid = 1'b0; mem_wack = 1'b1;
        @(negedge clk);
        mem_wack = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL ign_done: done=%b busy=%b need 1/0", done, busy);
        end
        @(negedge clk);
        total++;
        if ({done, busy, mem_rd, mem_wr} !== 4'b0000) begin
            bad++; $display("FAIL ign_no_second: done/busy/rd/wr=%b need 0000", {done, busy, mem_rd, mem_wr});
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; sbh_c = 2'd0; addr = 32'h0000_5000; data_in = 32'h0000_0001; mem_wack = 1'b1;
        @(posedge clk);
        #1 addr = 32'h0000_5008; data_in = 32'h0000_0002;
        @(negedge clk);
        total++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'h1 || mem_addr !== 32'h0000_5000) begin
            bad++; $display("FAIL b2b_first: wr=%b wdata=%h addr=%h need 1/00000001/00005000", mem_wr, mem_wdata, mem_addr);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL b2b_done1: done=%b busy=%b need 1/0", done, busy);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (mem_wr !== 1'b1 || mem_wdata !== 32'h2 || mem_addr !== 32'h0000_5008 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_second: wr=%b wdata=%h addr=%h done=%b need 1/00000002/00005008/0",
                            mem_wr, mem_wdata, mem_addr, done);
        end
        @(negedge clk);
        mem_wack = 1'b0;
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2: done=%b need 1", done); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        start = 1'b1; sbh_c = 2'd1; addr = 32'h0000_6001; data_in = 32'h0000_0077;
        mem_rdata = 32'h0; mem_rvalid = 1'b1; mem_wack = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++;
        if (mem_wr !== 1'b1) begin bad++; $display("FAIL rstmid_in_wr: wr=%b need 1", mem_wr); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, mem_rd, mem_wr, mem_addr, mem_wdata} !== 68'd0) begin
            bad++;
            $display("FAIL rstmid_async: busy=%b done=%b rd=%b wr=%b addr=%h wdata=%h need all 0",
                     busy, done, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        mem_wack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if ({busy, mem_wr, done} !== 3'b000) begin
                bad++; $display("FAIL rstmid_quiet%0d: busy/wr/done=%b need 000", k, {busy, mem_wr, done});
            end
        end
        mem_wack = 1'b0;
        run_store(2'd3, 32'h0000_600C, 32'hCAFE_F00D, 32'h0, 0, 0);
        total++;
        if (o_timeout !== 1'b0 || o_wdata !== 32'hCAFE_F00D || o_done_cyc != 2) begin
            bad++; $display("FAIL rstmid_after: timeout=%b wdata=%h done_cyc=%0d need 0/cafef00d/2",
                            o_timeout, o_wdata, o_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_byte_lanes();
        test_halfword();
        test_word();
        test_wait_states();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
